alu_1bit: RTL and testbench



---
 rtl/alu_1bit.sv | 109 ++++++++++
 tb/tb_alu_1bit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_1bit.sv
// Registered 1-bit ALU slice: logic ops, add/sub with carry chaining, SLT hook.
// Outputs follow the inputs sampled at each rising edge, one cycle later.
module alu_1bit #(
  parameter bit IS_LSB = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       Bnegate,
  input  logic       CIN,
  input  logic       Less,
  input  logic [2:0] operation,
  output logic       Result,
  output logic       cout,
  output logic       Set,
  output logic       Overflow
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_NOR  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_ADD  = 3'b100,
    OP_SLT  = 3'b101,
    OP_PASS = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  function automatic logic full_add_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic full_add_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic b_inv_s;
  logic ci_s;
  logic sum_s;
  logic co_s;

  logic result_d, result_q;
  logic cout_d, cout_q;
  logic set_d, set_q;
  logic overflow_d, overflow_q;

  // Operand conditioning and the full adder.
  always_comb begin
    b_inv_s = B ^ Bnegate;
    if (IS_LSB) begin
      ci_s = Bnegate;
    end else begin
      ci_s = CIN;
    end
    sum_s = full_add_sum(A, b_inv_s, ci_s);
    co_s  = full_add_carry(A, b_inv_s, ci_s);
  end

  // Operation decode; carry is only exposed for arithmetic codes.
  always_comb begin
    result_d   = 1'b0;
    cout_d     = 1'b0;
    set_d      = sum_s;
    overflow_d = ci_s ^ co_s;
    case (op_e'(operation))
      OP_AND:  result_d = A & b_inv_s;
      OP_NOR:  result_d = ~(A | b_inv_s);
      OP_OR:   result_d = A | b_inv_s;
      OP_XOR:  result_d = A ^ b_inv_s;
      OP_ADD: begin
        result_d = sum_s;
        cout_d   = co_s;
      end
      OP_SLT: begin
        result_d = Less;
        cout_d   = co_s;
      end
      OP_PASS: result_d = b_inv_s;
      OP_RSVD: result_d = 1'b0;
      default: begin
        result_d = 1'b0;
        cout_d   = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= 1'b0;
      cout_q     <= 1'b0;
      set_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      cout_q     <= cout_d;
      set_q      <= set_d;
      overflow_q <= overflow_d;
    end
  end

  assign Result   = result_q;
  assign cout     = cout_q;
  assign Set      = set_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_alu_1bit.sv
// Directed bench for alu_1bit: an LSB slice and a chained (non-LSB) slice share stimulus.
// Observed vectors are {Result, cout, Set, Overflow}.
module tb_alu_1bit;

  logic       clk;
  logic       rst_n;
  logic       a, b, bneg, cin, less;
  logic [2:0] op;

  logic l_res, l_cout, l_set, l_ovf;
  logic m_res, m_cout, m_set, m_ovf;

  int checks;
  int failures;

  alu_1bit #(.IS_LSB(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Bnegate(bneg), .CIN(cin),
    .Less(less), .operation(op),
    .Result(l_res), .cout(l_cout), .Set(l_set), .Overflow(l_ovf)
  );

  alu_1bit #(.IS_LSB(1'b0)) u_mid (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Bnegate(bneg), .CIN(cin),
    .Less(less), .operation(op),
    .Result(m_res), .cout(m_cout), .Set(m_set), .Overflow(m_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] lsb_vec();
    return {l_res, l_cout, l_set, l_ovf};
  endfunction

  function automatic logic [3:0] mid_vec();
    return {m_res, m_cout, m_set, m_ovf};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic ia, input logic ib, input logic ibn,
                       input logic icin, input logic iless, input logic [2:0] iop);
    @(negedge clk);
    a = ia; b = ib; bneg = ibn; cin = icin; less = iless; op = iop;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_and  [4];
  logic [3:0] exp_or   [4];
  logic [3:0] exp_xor  [4];
  logic [3:0] exp_add  [4];
  logic [3:0] exp_sub  [4];

  initial begin
    checks   = 0;
    failures = 0;
    exp_and = '{4'b0000, 4'b0010, 4'b0010, 4'b1001};
    exp_or  = '{4'b0000, 4'b1010, 4'b1010, 4'b1001};
    exp_xor = '{4'b0000, 4'b1010, 4'b1010, 4'b0001};
    exp_add = '{4'b0000, 4'b1010, 4'b1010, 4'b0101};
    exp_sub = '{4'b0100, 4'b1011, 4'b1110, 4'b0100};

    rst_n = 1'b0;
    a = 1'b1; b = 1'b1; bneg = 1'b0; cin = 1'b0; less = 1'b0; op = 3'b010;
    #1;
    chk("reset_init_lsb", lsb_vec(), 4'b0000);
    chk("reset_init_mid", mid_vec(), 4'b0000);
    repeat (2) @(posedge clk);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_or11", lsb_vec(), 4'b1001);

    // Asynchronous assertion between edges clears outputs at once.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_now", lsb_vec(), 4'b0000);
    @(posedge clk);
    #1;
    chk("reset_held_edge", lsb_vec(), 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_no_edge", lsb_vec(), 4'b0000);
    @(posedge clk);
    #1;
    chk("release_first", lsb_vec(), 4'b1001);

    for (int i = 0; i < 4; i++) begin
      apply(i[1], i[0], 1'b0, 1'b0, 1'b0, 3'b000);
      chk($sformatf("and_%0d", i), lsb_vec(), exp_and[i]);
    end
    for (int i = 0; i < 4; i++) begin
      apply(i[1], i[0], 1'b0, 1'b0, 1'b0, 3'b010);
      chk($sformatf("or_%0d", i), lsb_vec(), exp_or[i]);
    end
    for (int i = 0; i < 4; i++) begin
      apply(i[1], i[0], 1'b0, 1'b0, 1'b0, 3'b011);
      chk($sformatf("xor_%0d", i), lsb_vec(), exp_xor[i]);
    end
    for (int i = 0; i < 4; i++) begin
      apply(i[1], i[0], 1'b0, 1'b0, 1'b0, 3'b100);
      chk($sformatf("add_%0d", i), lsb_vec(), exp_add[i]);
    end
    for (int i = 0; i < 4; i++) begin
      apply(i[1], i[0], 1'b1, 1'b0, 1'b0, 3'b100);
      chk($sformatf("sub_%0d", i), lsb_vec(), exp_sub[i]);
    end

    // Chained carry: the LSB slice must ignore CIN.
    apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100);
    chk("chain_cin1_mid", mid_vec(), 4'b0100);
    chk("chain_cin1_lsb", lsb_vec(), 4'b1010);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
    chk("chain_cin0_mid", mid_vec(), 4'b1010);
    chk("chain_cin0_lsb", lsb_vec(), 4'b1010);

    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    chk("nor_00", lsb_vec(), 4'b1000);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101);
    chk("slt_less1", lsb_vec(), 4'b1100);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b101);
    chk("slt_less0", lsb_vec(), 4'b0011);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b110);
    chk("pass_bneg1", lsb_vec(), 4'b0011);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110);
    chk("pass_bneg0", lsb_vec(), 4'b1010);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111);
    chk("reserved_11", lsb_vec(), 4'b0001);

    // Inputs changed between edges must not show until the next edge.
    @(negedge clk);
    op = 3'b010;
    #1;
    chk("hold_between_edges", lsb_vec(), 4'b0001);
    @(posedge clk);
    #1;
    chk("after_edge_or11", lsb_vec(), 4'b1001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
